// File: rtl/zipdma_mchan_if.sv
// Wishbone control-port bundle for the ZipDMA multi-channel front end.
// The master drives cyc/stb/we/addr/wdata/sel; the slave returns stall/ack/rdata.
interface zipdma_mchan_if #(
  parameter int LGNCHAN = 2
);
  logic               cyc;
  logic               stb;
  logic               we;
  logic [LGNCHAN+1:0] addr;
  logic [31:0]        wdata;
  logic [3:0]         sel;
  logic               stall;
  logic               ack;
  logic [31:0]        rdata;

  modport master (output cyc, stb, we, addr, wdata, sel, input stall, ack, rdata);
  modport slave  (input cyc, stb, we, addr, wdata, sel, output stall, ack, rdata);
endinterface

// File: rtl/zipdma_mchan.sv
// Multi-channel descriptor store and round-robin scheduler feeding one shared
// DMA engine, with sticky per-channel DONE/ERR status and interrupts.
module zipdma_mchan #(
  parameter  int NCHAN         = 4,
  parameter  int ADDRESS_WIDTH = 30,
  parameter  int LGDMALENGTH   = 30,
  localparam int LGNCHAN       = $clog2(NCHAN)
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  zipdma_mchan_if.slave            swb,
  input  logic [31:0]              i_dev_ints,
  output logic                     o_dma_request,
  output logic                     o_dma_abort,
  input  logic                     i_dma_busy,
  input  logic                     i_dma_err,
  output logic [ADDRESS_WIDTH-1:0] o_src_addr,
  output logic [ADDRESS_WIDTH-1:0] o_dst_addr,
  output logic [LGDMALENGTH-1:0]   o_length,
  output logic [LGNCHAN-1:0]       o_chan,
  output logic [NCHAN-1:0]         o_chan_int,
  output logic                     o_interrupt
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [NCHAN-1:0]         arm_q, arm_d, done_q, done_d, err_q, err_d;
  logic [NCHAN-1:0]         inten_q, inten_d, trigen_q, trigen_d;
  logic [4:0]               trigsel_q [NCHAN];
  logic [4:0]               trigsel_d [NCHAN];
  logic [ADDRESS_WIDTH-1:0] src_q [NCHAN];
  logic [ADDRESS_WIDTH-1:0] src_d [NCHAN];
  logic [ADDRESS_WIDTH-1:0] dst_q [NCHAN];
  logic [ADDRESS_WIDTH-1:0] dst_d [NCHAN];
  logic [LGDMALENGTH-1:0]   len_q [NCHAN];
  logic [LGDMALENGTH-1:0]   len_d [NCHAN];

  logic [LGNCHAN-1:0]       chan_q, chan_d, last_grant_q, last_grant_d;
  logic [ADDRESS_WIDTH-1:0] src_out_q, src_out_d, dst_out_q, dst_out_d;
  logic [LGDMALENGTH-1:0]   len_out_q, len_out_d;
  logic                     request_q, request_d, abort_q, abort_d;
  logic                     ack_q, ack_d;
  logic [31:0]              rdata_q, rdata_d;

  logic                     wr_en, rd_en, found;
  logic [LGNCHAN-1:0]       bus_chan, gnt, cand;
  logic [1:0]               bus_reg;
  logic [NCHAN-1:0]         ctrl_wr, arm_wr, abort_wr, active, ready;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  assign bus_chan = swb.addr[LGNCHAN+1:2];
  assign bus_reg  = swb.addr[1:0];
  assign wr_en    = swb.cyc && swb.stb && swb.we;
  assign rd_en    = swb.cyc && swb.stb && !swb.we;

  // An ABORT written this cycle masks the channel from arbitration, so a
  // channel cannot be granted in the same cycle its ARM is being cleared.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ctrl_wr  = '0;
    arm_wr   = '0;
    abort_wr = '0;
    active   = '0;
    ready    = '0;
    found    = 1'b0;
    gnt      = '0;
    cand     = '0;
    for (int c = 0; c < NCHAN; c++) begin
      ctrl_wr[c]  = wr_en && (int'(bus_chan) == c) && (bus_reg == 2'd0);
      arm_wr[c]   = ctrl_wr[c] && swb.sel[0] && swb.wdata[0];
      abort_wr[c] = ctrl_wr[c] && swb.sel[0] && swb.wdata[1];
      active[c]   = (state_q != S_IDLE) && (int'(chan_q) == c);
      ready[c]    = arm_q[c] && (!trigen_q[c] || i_dev_ints[trigsel_q[c]]) && !abort_wr[c];
    end
    for (int i = 0; i < NCHAN; i++) begin
      cand = LGNCHAN'((int'(last_grant_q) + 1 + i) % NCHAN);
      if (!found && ready[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    arm_d        = arm_q;
    done_d       = done_q;
    err_d        = err_q;
    inten_d      = inten_q;
    trigen_d     = trigen_q;
    trigsel_d    = trigsel_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    chan_d       = chan_q;
    last_grant_d = last_grant_q;
    src_out_d    = src_out_q;
    dst_out_d    = dst_out_q;
    len_out_d    = len_out_q;
    request_d    = request_q;
    abort_d      = 1'b0;
    ack_d        = swb.cyc && swb.stb;
    rdata_d      = '0;

    for (int c = 0; c < NCHAN; c++) begin
      if (rd_en && int'(bus_chan) == c) begin
        case (bus_reg)
          2'd0:    rdata_d = {17'b0, active[c], trigen_q[c], trigsel_q[c], 3'b0,
                              inten_q[c], err_q[c], done_q[c], 1'b0, arm_q[c]};
          2'd1:    rdata_d = 32'(src_q[c]);
          2'd2:    rdata_d = 32'(dst_q[c]);
          default: rdata_d = 32'(len_q[c]);
        endcase
      end
      if (ctrl_wr[c] && swb.sel[0]) begin
        if (swb.wdata[2]) done_d[c] = 1'b0;
        if (swb.wdata[3]) err_d[c]  = 1'b0;
        inten_d[c] = swb.wdata[4];
        // A zero-length descriptor completes immediately without touching the engine.
        if (arm_wr[c] && !arm_q[c]) begin
          if (len_q[c] == '0) done_d[c] = 1'b1;
          else                arm_d[c]  = 1'b1;
        end
        if (abort_wr[c] && arm_q[c] && !active[c]) arm_d[c] = 1'b0;
      end
      if (ctrl_wr[c] && swb.sel[1] && !arm_q[c]) begin
        trigsel_d[c] = swb.wdata[12:8];
        trigen_d[c]  = swb.wdata[13];
      end
      if (wr_en && int'(bus_chan) == c && !arm_q[c]) begin
        case (bus_reg)
          2'd1:    src_d[c] = ADDRESS_WIDTH'(merge_bytes(32'(src_q[c]), swb.wdata, swb.sel));
          2'd2:    dst_d[c] = ADDRESS_WIDTH'(merge_bytes(32'(dst_q[c]), swb.wdata, swb.sel));
          2'd3:    len_d[c] = LGDMALENGTH'(merge_bytes(32'(len_q[c]), swb.wdata, swb.sel));
          default: ;
        endcase
      end
    end

    // Scheduler updates come last so a hardware status set beats a same-cycle W1C.
    case (state_q)
      S_IDLE: if (found) begin
        chan_d       = gnt;
        last_grant_d = gnt;
        src_out_d    = src_q[gnt];
        dst_out_d    = dst_q[gnt];
        len_out_d    = len_q[gnt];
        request_d    = 1'b1;
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort_wr[chan_q]) begin
          abort_d   = 1'b1;
          request_d = 1'b0;
          state_d   = S_DRAIN;
        end else if (i_dma_busy) begin
          request_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (!i_dma_busy) begin
          arm_d[chan_q] = 1'b0;
          if (i_dma_err || abort_wr[chan_q]) err_d[chan_q]  = 1'b1;
          else                               done_d[chan_q] = 1'b1;
          state_d = S_IDLE;
        end else if (abort_wr[chan_q]) begin
          abort_d = 1'b1;
          state_d = S_DRAIN;
        end
      end
      default: if (!i_dma_busy) begin
        arm_d[chan_q] = 1'b0;
        err_d[chan_q] = 1'b1;
        state_d       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      arm_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      inten_q      <= '0;
      trigen_q     <= '0;
      // NOTE: the descriptor arrays are reset because they are software-visible and must read 0.
      for (int c = 0; c < NCHAN; c++) begin
        trigsel_q[c] <= '0;
        src_q[c]     <= '0;
        dst_q[c]     <= '0;
        len_q[c]     <= '0;
      end
      chan_q       <= '0;
      last_grant_q <= LGNCHAN'(NCHAN - 1);
      src_out_q    <= '0;
      dst_out_q    <= '0;
      len_out_q    <= '0;
      request_q    <= 1'b0;
      abort_q      <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so all flops sample together.
      state_q      <= state_d;
      arm_q        <= arm_d;
      done_q       <= done_d;
      err_q        <= err_d;
      inten_q      <= inten_d;
      trigen_q     <= trigen_d;
      trigsel_q    <= trigsel_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      chan_q       <= chan_d;
      last_grant_q <= last_grant_d;
      src_out_q    <= src_out_d;
      dst_out_q    <= dst_out_d;
      len_out_q    <= len_out_d;
      request_q    <= request_d;
      abort_q      <= abort_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  assign swb.stall     = 1'b0;
  assign swb.ack       = ack_q;
  assign swb.rdata     = rdata_q;
  assign o_dma_request = request_q;
  assign o_dma_abort   = abort_q;
  assign o_src_addr    = src_out_q;
  assign o_dst_addr    = dst_out_q;
  assign o_length      = len_out_q;
  assign o_chan        = chan_q;
  assign o_chan_int    = inten_q & (done_q | err_q);
  assign o_interrupt   = |o_chan_int;
endmodule

// File: tb/tb_zipdma_mchan.sv
// Directed bench for zipdma_mchan: inputs change and outputs are sampled on the
// falling clock edge; the engine side is driven by hand.
module tb_zipdma_mchan;
  localparam int NCHAN = 4;
  localparam int AW    = 30;
  localparam int LW    = 30;

  logic              i_clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic [31:0]       dev_ints;
  logic              dma_request, dma_abort, dma_busy, dma_err;
  logic [AW-1:0]     src_addr, dst_addr;
  logic [LW-1:0]     length;
  logic [1:0]        chan;
  logic [NCHAN-1:0]  chan_int;
  logic              interrupt;

  int checks = 0;
  int errors = 0;

  zipdma_mchan_if #(.LGNCHAN(2)) swb ();

  zipdma_mchan #(.NCHAN(NCHAN), .ADDRESS_WIDTH(AW), .LGDMALENGTH(LW)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .swb           (swb),
    .i_dev_ints    (dev_ints),
    .o_dma_request (dma_request),
    .o_dma_abort   (dma_abort),
    .i_dma_busy    (dma_busy),
    .i_dma_err     (dma_err),
    .o_src_addr    (src_addr),
    .o_dst_addr    (dst_addr),
    .o_length      (length),
    .o_chan        (chan),
    .o_chan_int    (chan_int),
    .o_interrupt   (interrupt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input int ch, input int rg, input logic [31:0] d,
                          input logic [3:0] sel = 4'hf);
    swb.cyc   = 1'b1;
    swb.stb   = 1'b1;
    swb.we    = 1'b1;
    swb.addr  = 4'(ch * 4 + rg);
    swb.wdata = d;
    swb.sel   = sel;
    @(negedge i_clk);
    swb.cyc = 1'b0;
    swb.stb = 1'b0;
    swb.we  = 1'b0;
    check("wr_ack", 32'(swb.ack), 32'd1);
  endtask

  task automatic wb_check(input string tag, input int ch, input int rg, input logic [31:0] exp);
    swb.cyc  = 1'b1;
    swb.stb  = 1'b1;
    swb.we   = 1'b0;
    swb.addr = 4'(ch * 4 + rg);
    @(negedge i_clk);
    swb.cyc = 1'b0;
    swb.stb = 1'b0;
    check(tag, swb.rdata, exp);
  endtask

  // Expects a pending request for exp_ch, then runs the engine for one cycle of busy.
  task automatic serve(input int exp_ch, input logic [31:0] exp_src,
                       input logic [31:0] exp_len, input logic err_in);
    check("grant_req", 32'(dma_request), 32'd1);
    check("grant_chan", 32'(chan), 32'(exp_ch));
    check("grant_src", 32'(src_addr), exp_src);
    check("grant_len", 32'(length), exp_len);
    dma_busy = 1'b1;
    @(negedge i_clk);
    check("req_drop", 32'(dma_request), 32'd0);
    dma_busy = 1'b0;
    dma_err  = err_in;
    @(negedge i_clk);
    dma_err = 1'b0;
  endtask

  initial begin
    swb.cyc   = 1'b0;
    swb.stb   = 1'b0;
    swb.we    = 1'b0;
    swb.addr  = '0;
    swb.wdata = '0;
    swb.sel   = '0;
    dev_ints  = '0;
    dma_busy  = 1'b0;
    dma_err   = 1'b0;

    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst_req", 32'(dma_request), 32'd0);
    check("rst_abort", 32'(dma_abort), 32'd0);
    check("rst_src", 32'(src_addr), 32'd0);
    check("rst_int", 32'(interrupt), 32'd0);
    check("rst_ack", 32'(swb.ack), 32'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Channel 0 basic transfer
    wb_write(0, 1, 32'h1000);
    wb_write(0, 2, 32'h2000);
    wb_write(0, 3, 32'd64);
    wb_write(0, 0, 32'h11);
    @(negedge i_clk);
    check("c0_req", 32'(dma_request), 32'd1);
    check("c0_src", 32'(src_addr), 32'h1000);
    check("c0_dst", 32'(dst_addr), 32'h2000);
    check("c0_len", 32'(length), 32'd64);
    check("c0_chan", 32'(chan), 32'd0);
    dma_busy = 1'b1;
    repeat (10) @(negedge i_clk);
    check("c0_req_run", 32'(dma_request), 32'd0);
    wb_check("c0_ctrl_run", 0, 0, 32'h4011);
    dma_busy = 1'b0;
    @(negedge i_clk);
    check("c0_int", 32'(interrupt), 32'd1);
    check("c0_chan_int", 32'(chan_int), 32'h1);
    wb_check("c0_ctrl_done", 0, 0, 32'h14);
    wb_write(0, 0, 32'h14);
    check("c0_int_clr", 32'(interrupt), 32'd0);
    wb_check("c0_ctrl_clr", 0, 0, 32'h10);

    // Channels 1..3 made ready in the same cycle via a shared trigger
    for (int c = 1; c < 4; c++) begin
      wb_write(c, 1, 32'(c * 32'h100));
      wb_write(c, 2, 32'(c * 32'h200));
      wb_write(c, 3, 32'(c * 16));
      wb_write(c, 0, 32'h2001);
    end
    check("rr_gated", 32'(dma_request), 32'd0);
    dev_ints[0] = 1'b1;
    @(negedge i_clk);
    for (int c = 1; c < 4; c++) begin
      serve(c, 32'(c * 32'h100), 32'(c * 16), 1'b0);
      @(negedge i_clk);
    end
    wb_check("rr_c1_done", 1, 0, 32'h2004);
    dev_ints[0] = 1'b0;
    for (int c = 1; c < 4; c++) wb_write(c, 0, 32'h2005);
    wb_check("rr_c1_rearm", 1, 0, 32'h2001);
    dev_ints[0] = 1'b1;
    @(negedge i_clk);
    for (int c = 1; c < 4; c++) begin
      serve(c, 32'(c * 32'h100), 32'(c * 16), 1'b0);
      @(negedge i_clk);
    end
    dev_ints[0] = 1'b0;

    // Channel 2 gated by trigger 5
    wb_write(2, 0, 32'h2505);
    repeat (3) @(negedge i_clk);
    check("trig_wait", 32'(dma_request), 32'd0);
    dev_ints[5] = 1'b1;
    @(negedge i_clk);
    serve(2, 32'h200, 32'd32, 1'b0);
    dev_ints[5] = 1'b0;

    // Abort channel 0 in RUN; channel 1 waits and is granted next
    wb_write(0, 0, 32'h11);
    wb_write(1, 0, 32'h05);
    check("ab_req", 32'(dma_request), 32'd1);
    check("ab_chan", 32'(chan), 32'd0);
    dma_busy = 1'b1;
    @(negedge i_clk);
    wb_write(0, 0, 32'h12);
    check("ab_pulse", 32'(dma_abort), 32'd1);
    check("ab_req_low", 32'(dma_request), 32'd0);
    @(negedge i_clk);
    check("ab_pulse_end", 32'(dma_abort), 32'd0);
    wb_check("ab_ctrl_drain", 0, 0, 32'h4011);
    dma_busy = 1'b0;
    @(negedge i_clk);
    check("ab_err_int", 32'(chan_int), 32'h1);
    check("ab_no_req", 32'(dma_request), 32'd0);
    wb_check("ab_ctrl_err", 0, 0, 32'h18);
    serve(1, 32'h100, 32'd16, 1'b0);
    wb_write(0, 0, 32'h18);

    // Zero-length arm and byte-enable handling on channel 3
    wb_write(3, 3, 32'd0);
    wb_write(3, 0, 32'h04);
    wb_check("z_ctrl_clr", 3, 0, 32'h0);
    wb_write(3, 0, 32'h11);
    check("z_chan_int", 32'(chan_int), 32'h8);
    check("z_no_req", 32'(dma_request), 32'd0);
    wb_check("z_ctrl", 3, 0, 32'h14);
    wb_write(3, 1, 32'hFFFF_FFAB, 4'b0001);
    wb_check("sel_src", 3, 1, 32'h3AB);
    wb_write(3, 0, 32'h04);

    // Engine error on channel 2
    wb_write(2, 0, 32'h15);
    @(negedge i_clk);
    serve(2, 32'h200, 32'd32, 1'b1);
    check("err_chan_int", 32'(chan_int), 32'h4);
    wb_check("err_ctrl", 2, 0, 32'h18);

    // Hardware DONE set wins over a same-cycle W1C
    wb_write(1, 0, 32'h05);
    @(negedge i_clk);
    check("race_chan", 32'(chan), 32'd1);
    dma_busy = 1'b1;
    @(negedge i_clk);
    dma_busy = 1'b0;
    wb_write(1, 0, 32'h04);
    wb_check("race_done", 1, 0, 32'h04);

    // Armed descriptor is write-protected; async reset mid-RUN
    wb_write(0, 0, 32'h11);
    wb_write(0, 1, 32'hDEAD0);
    check("prot_req", 32'(dma_request), 32'd1);
    wb_check("prot_src", 0, 1, 32'h1000);
    dma_busy = 1'b1;
    @(negedge i_clk);
    check("pre_rst_src", 32'(src_addr), 32'h1000);
    check("pre_rst_int", 32'(chan_int), 32'h4);
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_src", 32'(src_addr), 32'd0);
    check("arst_len", 32'(length), 32'd0);
    check("arst_int", 32'(interrupt), 32'd0);
    check("arst_chan_int", 32'(chan_int), 32'd0);
    check("arst_req", 32'(dma_request), 32'd0);
    @(negedge i_clk);
    dma_busy  = 1'b0;
    i_reset_n = 1'b1;
    @(negedge i_clk);
    wb_check("post_rst_src", 0, 1, 32'd0);
    wb_check("post_rst_ctrl", 0, 0, 32'd0);
    wb_check("post_rst_c2", 2, 0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
